// File: rtl/dmem_pkg.sv
// Shared types and constants for the variable-latency data-memory responder.
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_BOTH  = 2'd3
  } err_cause_t;

  // Conflicting read+write outranks address faults; alignment outranks range.
  function automatic err_cause_t classify(input logic [ADDR_W-1:0] addr, input logic rd,
                                          input logic wr, input int idx_w);
    err_cause_t cause;
    if (rd && wr) begin
      cause = ERR_BOTH;
    end else if (addr[1:0] != 2'b00) begin
      cause = ERR_ALIGN;
    end else if ((addr >> (idx_w + 2)) != {ADDR_W{1'b0}}) begin
      cause = ERR_RANGE;
    end else begin
      cause = ERR_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with synchronous write and combinational read; contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] memory [DEPTH_WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      memory[idx] <= wdata;
    end
  end

  assign rdata = memory[idx];

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data-memory slave: accepts one request, stalls LATENCY cycles,
// then pulses rsp_valid with load data or an error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_read,
  input  logic              req_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_t            r_state;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_read;
  logic              r_write;
  logic [DATA_W-1:0] r_rdata;
  logic              r_valid;
  err_cause_t        r_err_cause;

  logic              w_req;
  logic              w_access;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_read;
  logic              w_acc_write;
  err_cause_t        w_cause;
  logic [IDX_W-1:0]  w_idx;
  logic              w_we;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_req = req_read | req_write;

  // With zero latency the access happens on the accept edge, so it must use the live request.
  always_comb begin
    w_access    = 1'b0;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    w_acc_read  = r_read;
    w_acc_write = r_write;
    if (r_state == IDLE) begin
      w_access    = w_req && (LAT == 4'd0);
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
      w_acc_read  = req_read;
      w_acc_write = req_write;
    end else if (r_state == WAIT) begin
      w_access = (r_count == 4'd1);
    end else begin
      w_access = 1'b0;
    end
  end

  assign w_cause = classify(w_acc_addr, w_acc_read, w_acc_write, IDX_W);
  assign w_idx   = w_acc_addr[IDX_W+1:2];
  // Gating with reset keeps an abandoned write out of the array while reset is held.
  assign w_we    = reset & w_access & w_acc_write & (w_cause == ERR_NONE);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (w_we),
    .idx  (w_idx),
    .wdata(w_acc_wdata),
    .rdata(w_mem_rdata)
  );

  // Request FSM, wait counter and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rdata     <= {DATA_W{1'b0}};
      r_valid     <= 1'b0;
      r_err_cause <= ERR_NONE;
    end else begin
      r_valid     <= w_access;
      r_err_cause <= w_access ? w_cause : ERR_NONE;
      if (w_access) begin
        if (w_cause != ERR_NONE) begin
          r_rdata <= {DATA_W{1'b0}};
        end else if (w_acc_read) begin
          r_rdata <= w_mem_rdata;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_read  <= req_read;
            r_write <= req_write;
            r_count <= LAT;
            r_state <= (LAT == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_valid = r_valid;
  assign rsp_err   = (r_err_cause != ERR_NONE);
  assign busy      = w_req & ~r_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, driven from a vector table,
// hand sequences and random transactions checked against a transaction-level memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_addr [2];
  logic [31:0] a_wdata[2];
  logic        a_rd   [2];
  logic        a_wr   [2];
  logic [31:0] o_rdata[2];
  logic        o_valid[2];
  logic        o_err  [2];
  logic        o_busy [2];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model[2][256];
  logic [31:0] hold [2];
  int          lat  [2];

  typedef struct {
    int          u;
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    logic        e;
    logic [31:0] r;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_addr(a_addr[0]), .req_wdata(a_wdata[0]),
    .req_read(a_rd[0]), .req_write(a_wr[0]), .rsp_rdata(o_rdata[0]),
    .rsp_valid(o_valid[0]), .rsp_err(o_err[0]), .busy(o_busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_addr(a_addr[1]), .req_wdata(a_wdata[1]),
    .req_read(a_rd[1]), .req_write(a_wr[1]), .rsp_rdata(o_rdata[1]),
    .rsp_valid(o_valid[1]), .rsp_err(o_err[1]), .busy(o_busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic err_of(input logic [31:0] a, input logic rd, input logic wr);
    return (a[1:0] != 2'b00) || (a >= 32'h400) || (rd && wr);
  endfunction

  task automatic add(input int u, input logic [31:0] a, input logic [31:0] d, input logic rd,
                     input logic wr, input logic e, input logic [31:0] r, input string nm);
    vec_t v;
    v.u = u; v.a = a; v.d = d; v.rd = rd; v.wr = wr; v.e = e; v.r = r; v.nm = nm;
    tbl.push_back(v);
  endtask

  // One complete transaction starting from an idle unit, sampled 1 time unit after each edge.
  task automatic txn(input int u, input logic [31:0] a, input logic [31:0] d, input logic rd,
                     input logic wr, input logic e, input logic [31:0] r, input string nm);
    a_addr[u] = a; a_wdata[u] = d; a_rd[u] = rd; a_wr[u] = wr;
    #1;
    chk({nm, "/busy_req"}, 32'(o_busy[u]), 32'd1);
    for (int k = 0; k <= lat[u]; k++) begin
      @(posedge clk); #1;
      if (k < lat[u]) begin
        chk({nm, "/valid_wait"}, 32'(o_valid[u]), 32'd0);
        chk({nm, "/busy_wait"}, 32'(o_busy[u]), 32'd1);
        if (k == 0) begin
          a_addr[u]  = $urandom;
          a_wdata[u] = $urandom;
        end
      end else begin
        chk({nm, "/valid"}, 32'(o_valid[u]), 32'd1);
        chk({nm, "/err"}, 32'(o_err[u]), 32'(e));
        chk({nm, "/rdata"}, o_rdata[u], r);
        chk({nm, "/busy_done"}, 32'(o_busy[u]), 32'd0);
      end
    end
    a_rd[u] = 1'b0; a_wr[u] = 1'b0; a_addr[u] = $urandom;
    #1;
    chk({nm, "/busy_idle"}, 32'(o_busy[u]), 32'd0);
    @(posedge clk); #1;
    chk({nm, "/valid_after"}, 32'(o_valid[u]), 32'd0);
    chk({nm, "/err_after"}, 32'(o_err[u]), 32'd0);
    chk({nm, "/rdata_hold"}, o_rdata[u], r);
    if (!e && wr) model[u][a[9:2]] = d;
    hold[u] = r;
  endtask

  task automatic rand_txn(input int u, input int n);
    logic [31:0] a;
    logic        rd, wr, e;
    logic [31:0] r;
    int          sel;
    sel = $urandom_range(0, 9);
    a = {22'd0, 8'($urandom), 2'b00};
    if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (sel == 1) a = 32'h400 | ($urandom & 32'hFFFF_FFFC);
    sel = $urandom_range(0, 4);
    rd = (sel <= 1) || (sel == 4);
    wr = (sel >= 2);
    e = err_of(a, rd, wr);
    r = e ? 32'd0 : (rd ? model[u][a[9:2]] : hold[u]);
    txn(u, a, $urandom, rd, wr, e, r, $sformatf("rand%0d_u%0d", n, u));
  endtask

  task automatic mem_cmp(input int u, input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (u == 0) begin
        if (dut.u_array.memory[i] !== model[0][i]) bad++;
      end else begin
        if (dut0.u_array.memory[i] !== model[1][i]) bad++;
      end
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [11:0] vbits, bbits;
    int          vcnt;
    lat[0] = 2; lat[1] = 0;
    hold[0] = 32'd0; hold[1] = 32'd0;
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      a_addr[u] = 32'd0; a_wdata[u] = 32'd0; a_rd[u] = 1'b0; a_wr[u] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      model[0][i] = 32'(i * 7 + 3);
      model[1][i] = 32'(i * 13 + 1);
      dut.u_array.memory[i]  = model[0][i];
      dut0.u_array.memory[i] = model[1][i];
    end
    model[0][5] = 32'hDEAD_BEEF; dut.u_array.memory[5]  = 32'hDEAD_BEEF;
    model[1][0] = 32'd7;         dut0.u_array.memory[0] = 32'd7;

    #12;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_valid_u%0d", u), 32'(o_valid[u]), 32'd0);
      chk($sformatf("reset_err_u%0d", u), 32'(o_err[u]), 32'd0);
      chk($sformatf("reset_rdata_u%0d", u), o_rdata[u], 32'd0);
      chk($sformatf("reset_busy_u%0d", u), 32'(o_busy[u]), 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    add(0, 32'h14,  32'h0,         1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, "rd_preload");
    add(0, 32'h20,  32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, "wr_20");
    add(0, 32'h20,  32'h0,         1'b1, 1'b0, 1'b0, 32'h1234_5678, "rd_20");
    add(0, 32'h21,  32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         "rd_misalign");
    add(0, 32'h400, 32'h55,        1'b0, 1'b1, 1'b1, 32'h0,         "wr_range");
    add(0, 32'h10,  32'h66,        1'b1, 1'b1, 1'b1, 32'h0,         "rd_wr_both");
    add(0, 32'h20,  32'h0,         1'b1, 1'b0, 1'b0, 32'h1234_5678, "rd_20_again");
    add(0, 32'h3FC, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h1234_5678, "wr_top");
    add(0, 32'h3FC, 32'h0,         1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, "rd_top");
    add(0, 32'h3FE, 32'h1,         1'b0, 1'b1, 1'b1, 32'h0,         "wr_misalign");
    add(1, 32'h0,   32'h0,         1'b1, 1'b0, 1'b0, 32'd7,         "l0_rd0");
    add(1, 32'h4,   32'd99,        1'b0, 1'b1, 1'b0, 32'd7,         "l0_wr4");
    add(1, 32'h4,   32'h0,         1'b1, 1'b0, 1'b0, 32'd99,        "l0_rd4");
    add(1, 32'h1,   32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         "l0_misalign");
    add(1, 32'h400, 32'h5,         1'b0, 1'b1, 1'b1, 32'h0,         "l0_range");
    foreach (tbl[i]) txn(tbl[i].u, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].e, tbl[i].r, tbl[i].nm);
    mem_cmp(0, "mem_after_table_u0");
    mem_cmp(1, "mem_after_table_u1");

    // Read held across DONE: one completion every LATENCY+2 cycles.
    a_addr[0] = 32'h14; a_rd[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      vbits[k] = o_valid[0];
      bbits[k] = o_busy[0];
    end
    chk("b2b_valid_pattern", 32'(vbits), 32'h444);
    chk("b2b_busy_pattern", 32'(bbits), 32'hBBB);
    chk("b2b_rdata", o_rdata[0], model[0][5]);
    a_rd[0] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_valid_after", 32'(o_valid[0]), 32'd0);
    hold[0] = model[0][5];

    // Reset while a write is waiting: memory untouched, no late completion.
    model[0][2] = 32'd20; dut.u_array.memory[2] = 32'd20;
    a_addr[0] = 32'h8; a_wdata[0] = 32'hAAAA; a_wr[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_err", 32'(o_err[0]), 32'd0);
    chk("rst_rdata_u0", o_rdata[0], 32'd0);
    chk("rst_rdata_u1", o_rdata[1], 32'd0);
    @(posedge clk); @(posedge clk); #1;
    a_wr[0] = 1'b0;
    @(negedge clk); reset = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      vcnt += int'(o_valid[0]);
    end
    chk("rst_no_valid", 32'(vcnt), 32'd0);
    chk("rst_mem2", dut.u_array.memory[2], 32'd20);
    hold[0] = 32'd0; hold[1] = 32'd0;

    for (int n = 0; n < 40; n++) rand_txn(0, n);
    for (int n = 0; n < 25; n++) rand_txn(1, n);
    mem_cmp(0, "mem_final_u0");
    mem_cmp(1, "mem_final_u1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port, replacing the single-cycle data memory with a variable-latency slave.
- Accepts a read or write request, inserts LATENCY wait states while asserting a stall toward the CPU, then returns one completion pulse.
- Sits between the EXMEM stage (address, write data, MemRead, MemWrite) and the MEMWB stage. Its stall drives the pipeline hold logic.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Must be a power of two, at least 4.
- LATENCY, 2: wait cycles between request acceptance and completion. Range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_read  in  1  read request (MemRead)
- req_write  in  1  write request (MemWrite)
- rsp_rdata  out  32  load data; valid while rsp_valid=1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  error flag; qualified by rsp_valid
- busy  out  1  stall to CPU (holds PC, IFID, IDEX, EXMEM)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Memory array is not cleared.
- States: IDLE, WAIT, DONE (2-bit encoding).
- IDLE:
  - If req_read or req_write is 1 at a rising edge, latch addr, wdata, read, write and load counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise DONE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1, perform the access and go to DONE.
  - The access is performed on the edge entering DONE:
    - Write: mem[idx] <= wdata.
    - Read: rsp_rdata <= mem[idx].
- DONE:
  - rsp_valid=1 for exactly this cycle, then unconditional return to IDLE.
  - No request is sampled in DONE.
  - The minimum gap between completions is LATENCY+2 cycles.
- Latency: a request first sampled at edge E0 produces rsp_valid high in the cycle after edge E0+LATENCY.
- busy (combinational):
  - busy = (req_read | req_write) & ~rsp_valid.
  - Consequence: busy is high from the first request cycle through the last wait cycle and low in the DONE cycle, so the pipeline advances exactly on the completion edge.
  - busy=0 whenever no request is present.
- Address decode: idx = req_addr[log2(DEPTH_WORDS)+1:2].
- Error conditions. Any of the following completes with the normal latency, rsp_err=1, rsp_rdata=0 and no memory write:
  - req_addr[1:0] != 0 (misaligned)
  - req_addr >= 4*DEPTH_WORDS (out of range)
  - req_read and req_write both 1
- The CPU holds the request stable until rsp_valid. Any change after acceptance is ignored, because latched values are used.
- rsp_rdata holds its last value after DONE. It changes only on a successful read completion, or is cleared on an error completion.
- rsp_err=0 in every cycle where rsp_valid=0.
- Reset mid-operation: the pending access is abandoned. A write that has not reached the DONE edge does not modify memory. No rsp_valid is produced.

Decomposition:
- Package dmem_pkg holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2
  - ADDR_W=32, DATA_W=32
  - error-cause constants: ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_BOTH. These are for debug visibility only and are not ports.
- Sub-module dmem_array: a synchronous single-port word array (clk, we, idx, wdata, rdata). It is not reset, and has a hierarchical `memory` for bench preload.
- FSM, counter, decode and error logic stay in dmem_responder.

Test Plan:
- Read: preload memory[5]=32'hDEADBEEF, LATENCY=2, req_read=1, req_addr=32'h14 at E0. Expected: busy=1 for 3 cycles; rsp_valid high in the cycle after E0+2 with rsp_rdata=32'hDEADBEEF, rsp_err=0; busy low that cycle.
- Write then read: write 32'h12345678 to addr 32'h20, then read 32'h20. Expected: the read returns 32'h12345678, with two rsp_valid pulses spaced at least 4 cycles apart.
- Errors:
  - Read of addr 32'h21 (misaligned): rsp_err=1, rsp_rdata=0.
  - Write to 32'h400 with DEPTH_WORDS=256 (out of range): rsp_err=1; all memory words unchanged.
  - req_read=req_write=1: rsp_err=1.
- LATENCY=0: read of addr 0 (memory[0]=7). Expected: rsp_valid in the cycle after E0, rsp_rdata=7, busy high for exactly 1 cycle.
- Reset mid-write: write 32'hAAAA to addr 8 (memory[2]=20), assert reset low during WAIT. Expected: outputs go to 0 immediately; memory[2] stays 20; no rsp_valid after reset deasserts.
- Back-to-back reads with request held across DONE. Expected: the second access is accepted only at the edge after DONE, giving exactly one rsp_valid per LATENCY+2 cycles.
